// File: rtl/region_rom_loader.sv
// region_rom_loader
//   Splits the hps_io ROM download stream into per-region writes. The stream is
//   a sequence of records, one per region in load order: a 4-byte big-endian
//   byte count followed by that many data bytes. Each region targets either
//   SDRAM (REGION_CS all-zero, base address added, one request/ack handshake
//   per byte) or a block RAM selected by REGION_CS (region-relative address,
//   one-cycle write strobe). Records past the last region are swallowed.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   ioctl_download      download window; falling edge aborts and pulses load_done
//   ioctl_wr/ioctl_dout one-cycle byte strobe and byte from hps_io
//   ioctl_wait          back-pressure; high while an SDRAM write is outstanding
//   sdr_addr/data/be    SDRAM byte write (byte replicated in both lanes)
//   sdr_req/sdr_ack     request held until the one-cycle ack
//   bram_addr/data/cs   BRAM write, offset within region, cs valid with bram_wr
//   bram_wr             one-cycle BRAM write strobe
//   region              current region index, NUM_REGIONS means discard
//   busy                high from the first accepted byte until back in idle
//   load_done           one-cycle pulse when the download window closes
module region_rom_loader #(
   parameter int NUM_REGIONS = 5,
   parameter int CS_W = 5,
   parameter logic [NUM_REGIONS-1:0][24:0]     REGION_BASE = '0,
   parameter logic [NUM_REGIONS-1:0][CS_W-1:0] REGION_CS   = '0,
   parameter logic [NUM_REGIONS-1:0][1:0]      REGION_MODE = '0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ioctl_download,
   input  logic                               ioctl_wr,
   input  logic [7:0]                         ioctl_dout,
   output logic                               ioctl_wait,
   output logic [24:0]                        sdr_addr,
   output logic [15:0]                        sdr_data,
   output logic [1:0]                         sdr_be,
   output logic                               sdr_req,
   input  logic                               sdr_ack,
   output logic [24:0]                        bram_addr,
   output logic [7:0]                         bram_data,
   output logic [CS_W-1:0]                    bram_cs,
   output logic                               bram_wr,
   output logic [$clog2(NUM_REGIONS+1)-1:0]   region,
   output logic                               busy,
   output logic                               load_done
);

   localparam int RW = $clog2(NUM_REGIONS+1);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_WAIT_SDR} state_t;

   state_t          state_reg;
   logic [RW-1:0]   region_reg;
   logic [1:0]      hdr_cnt_reg;
   logic [23:0]     hdr_reg;
   logic [31:0]     size_reg;
   logic [31:0]     offset_reg;
   logic            dl_prev_reg;
   logic            abort_pend_reg;
   logic            ret_hdr_reg;
   logic            wait_reg;
   logic [24:0]     sdr_addr_reg;
   logic [15:0]     sdr_data_reg;
   logic [1:0]      sdr_be_reg;
   logic            sdr_req_reg;
   logic [24:0]     bram_addr_reg;
   logic [7:0]      bram_data_reg;
   logic [CS_W-1:0] bram_cs_reg;
   logic            bram_wr_reg;
   logic            busy_reg;
   logic            load_done_reg;

   // Per-region tables unpacked from the parameter vectors.
   logic [24:0]     base_tbl [NUM_REGIONS];
   logic [CS_W-1:0] cs_tbl   [NUM_REGIONS];
   logic [1:0]      mode_tbl [NUM_REGIONS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region_tbl
         assign base_tbl[gi] = REGION_BASE[gi];
         assign cs_tbl[gi]   = REGION_CS[gi];
         assign mode_tbl[gi] = REGION_MODE[gi];
      end
   endgenerate

   logic [24:0]     cur_base;
   logic [CS_W-1:0] cur_cs;
   logic [1:0]      cur_mode;
   logic [24:0]     off_lin;
   logic [24:0]     off_map;
   logic [24:0]     sdr_target;
   logic [31:0]     hdr_size;
   logic            in_discard;
   logic            accept;
   logic            dl_fall;
   logic            last_byte;

   // Region lookup; the discard index matches no entry and yields zeros.
   always_comb begin
      cur_base = '0;
      cur_cs   = '0;
      cur_mode = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (region_reg == RW'(i)) begin
            cur_base = base_tbl[i];
            cur_cs   = cs_tbl[i];
            cur_mode = mode_tbl[i];
         end
      end
   end

   assign off_lin = offset_reg[24:0];

   always_comb begin
      case (cur_mode)
         2'd1:    off_map = {off_lin[24:3], off_lin[1:0], off_lin[2]};
         2'd2:    off_map = {off_lin[24:1], ~off_lin[0]};
         default: off_map = off_lin;
      endcase
   end

   assign sdr_target = cur_base + off_map;   // wraps modulo 2^25
   assign hdr_size   = {hdr_reg, ioctl_dout};
   assign in_discard = (region_reg == RW'(NUM_REGIONS));
   // Bytes strobed while wait is high are protocol violations and dropped.
   assign accept     = ioctl_download & ioctl_wr & ~wait_reg;
   assign dl_fall    = dl_prev_reg & ~ioctl_download;
   assign last_byte  = ((offset_reg + 32'd1) == size_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         region_reg     <= '0;
         hdr_cnt_reg    <= '0;
         hdr_reg        <= '0;
         size_reg       <= '0;
         offset_reg     <= '0;
         dl_prev_reg    <= 1'b0;
         abort_pend_reg <= 1'b0;
         ret_hdr_reg    <= 1'b0;
         wait_reg       <= 1'b0;
         sdr_addr_reg   <= '0;
         sdr_data_reg   <= '0;
         sdr_be_reg     <= '0;
         sdr_req_reg    <= 1'b0;
         bram_addr_reg  <= '0;
         bram_data_reg  <= '0;
         bram_cs_reg    <= '0;
         bram_wr_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         load_done_reg  <= 1'b0;
      end else begin
         dl_prev_reg   <= ioctl_download;
         bram_wr_reg   <= 1'b0;
         bram_cs_reg   <= '0;
         load_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               busy_reg <= 1'b0;
               if (dl_fall)
                  load_done_reg <= 1'b1;
               if (ioctl_download) begin
                  state_reg      <= S_HDR;
                  region_reg     <= '0;
                  hdr_cnt_reg    <= '0;
                  offset_reg     <= '0;
                  abort_pend_reg <= 1'b0;
               end
            end
            S_HDR: begin
               if (dl_fall) begin
                  state_reg     <= S_IDLE;   // partial header is simply dropped
                  load_done_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end else if (accept) begin
                  busy_reg <= 1'b1;
                  if (!in_discard) begin
                     if (hdr_cnt_reg == 2'd3) begin
                        hdr_cnt_reg <= '0;
                        size_reg    <= hdr_size;
                        if (hdr_size == 32'd0) begin
                           region_reg <= region_reg + RW'(1);
                        end else begin
                           state_reg  <= S_DATA;
                           offset_reg <= '0;
                        end
                     end else begin
                        hdr_reg     <= {hdr_reg[15:0], ioctl_dout};
                        hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                     end
                  end
               end
            end
            S_DATA: begin
               if (dl_fall) begin
                  state_reg     <= S_IDLE;
                  load_done_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end else if (accept) begin
                  busy_reg   <= 1'b1;
                  offset_reg <= offset_reg + 32'd1;
                  if (last_byte)
                     region_reg <= region_reg + RW'(1);
                  if (cur_cs == '0) begin
                     sdr_addr_reg <= sdr_target;
                     sdr_data_reg <= {ioctl_dout, ioctl_dout};
                     sdr_be_reg   <= sdr_target[0] ? 2'b10 : 2'b01;
                     sdr_req_reg  <= 1'b1;
                     wait_reg     <= 1'b1;
                     ret_hdr_reg  <= last_byte;
                     state_reg    <= S_WAIT_SDR;
                  end else begin
                     bram_addr_reg <= off_map;
                     bram_data_reg <= ioctl_dout;
                     bram_cs_reg   <= cur_cs;
                     bram_wr_reg   <= 1'b1;
                     state_reg     <= last_byte ? S_HDR : S_DATA;
                  end
               end
            end
            S_WAIT_SDR: begin
               // An abort here must not strand the SDRAM controller mid-write,
               // so it is remembered and taken only once the ack arrives.
               if (sdr_ack) begin
                  sdr_req_reg <= 1'b0;
                  wait_reg    <= 1'b0;
                  if (abort_pend_reg || dl_fall) begin
                     state_reg      <= S_IDLE;
                     load_done_reg  <= 1'b1;
                     busy_reg       <= 1'b0;
                     abort_pend_reg <= 1'b0;
                  end else begin
                     state_reg <= ret_hdr_reg ? S_HDR : S_DATA;
                  end
               end else if (dl_fall) begin
                  abort_pend_reg <= 1'b1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign ioctl_wait = wait_reg;
   assign sdr_addr   = sdr_addr_reg;
   assign sdr_data   = sdr_data_reg;
   assign sdr_be     = sdr_be_reg;
   assign sdr_req    = sdr_req_reg;
   assign bram_addr  = bram_addr_reg;
   assign bram_data  = bram_data_reg;
   assign bram_cs    = bram_cs_reg;
   assign bram_wr    = bram_wr_reg;
   assign region     = region_reg;
   assign busy       = busy_reg;
   assign load_done  = load_done_reg;

endmodule

// File: tb/tb_region_rom_loader.sv
// Scoreboard bench for region_rom_loader: each download's byte stream is parsed
// by a record-level reference model that queues the expected writes; a monitor
// pops and compares them as the loader presents SDRAM requests or BRAM strobes.
module tb_region_rom_loader;

   localparam int NR   = 5;
   localparam int CS_W = 5;
   localparam int RW   = $clog2(NR+1);

   // Region map: 0 SDRAM linear, 1 SDRAM reorder_64, 2 BRAM linear,
   // 3 SDRAM swap16 near the top of memory, 4 BRAM reorder_64.
   localparam logic [NR-1:0][24:0] BASE =
      {25'h000_0000, 25'h1FF_FFFC, 25'h000_0123, 25'h040_0000, 25'h000_0000};
   localparam logic [NR-1:0][CS_W-1:0] CSV =
      {5'b10000, 5'b00000, 5'b00010, 5'b00000, 5'b00000};
   localparam logic [NR-1:0][1:0] MODE = {2'd1, 2'd2, 2'd0, 2'd1, 2'd0};

   logic            clk;
   logic            rst;
   logic            ioctl_download;
   logic            ioctl_wr;
   logic [7:0]      ioctl_dout;
   logic            ioctl_wait;
   logic [24:0]     sdr_addr;
   logic [15:0]     sdr_data;
   logic [1:0]      sdr_be;
   logic            sdr_req;
   logic            sdr_ack;
   logic [24:0]     bram_addr;
   logic [7:0]      bram_data;
   logic [CS_W-1:0] bram_cs;
   logic            bram_wr;
   logic [RW-1:0]   region;
   logic            busy;
   logic            load_done;

   region_rom_loader #(
      .NUM_REGIONS(NR), .CS_W(CS_W),
      .REGION_BASE(BASE), .REGION_CS(CSV), .REGION_MODE(MODE)
   ) dut (
      .clk(clk), .reset(rst),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait),
      .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
      .sdr_req(sdr_req), .sdr_ack(sdr_ack),
      .bram_addr(bram_addr), .bram_data(bram_data), .bram_cs(bram_cs), .bram_wr(bram_wr),
      .region(region), .busy(busy), .load_done(load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_sdr;
      logic [24:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
      logic [4:0]  cs;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   ld_count = 0;
   int   ack_min  = 0;
   int   dl_num   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Offset remap from the mode rules, done with arithmetic on the low 3 bits.
   function automatic logic [24:0] map_off(input int mode, input int k);
      int lo;
      case (mode)
         1: begin
            lo = k % 8;
            return 25'(k - lo + (lo % 4) * 2 + lo / 4);
         end
         2:       return 25'(k ^ 1);
         default: return 25'(k);
      endcase
   endfunction

   // Walk the sent bytes record by record and queue every write they cause.
   task automatic model_stream(input logic [7:0] s[$], output int reg_final);
      int   idx;
      int   r;
      int   sz;
      bit   stop;
      exp_t e;
      logic [24:0] m;
      idx = 0; r = 0; stop = 0;
      while (r < NR && !stop) begin
         if (idx + 4 > s.size()) begin
            stop = 1;
         end else begin
            sz = int'({s[idx], s[idx+1], s[idx+2], s[idx+3]});
            idx += 4;
            for (int k = 0; k < sz; k++) begin
               if (idx >= s.size()) begin
                  stop = 1;
                  break;
               end
               m = map_off(int'(MODE[r]), k);
               if (CSV[r] == '0) begin
                  e.is_sdr = 1;
                  e.addr   = BASE[r] + m;
                  e.data   = {s[idx], s[idx]};
                  e.be     = e.addr[0] ? 2'b10 : 2'b01;
                  e.cs     = '0;
               end else begin
                  e.is_sdr = 0;
                  e.addr   = m;
                  e.data   = {8'h00, s[idx]};
                  e.be     = '0;
                  e.cs     = CSV[r];
               end
               exp_q.push_back(e);
               idx++;
            end
            if (!stop) r++;
         end
      end
      reg_final = r;
   endtask

   // SDRAM responder: random ack latency plus occasional stray acks.
   initial begin
      int dly;
      dly = -1;
      sdr_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         sdr_ack = 1'b0;
         if (rst) begin
            dly = -1;
         end else if (sdr_req) begin
            if (dly < 0) dly = $urandom_range(ack_min + 3, ack_min);
            if (dly == 0) begin
               sdr_ack = 1'b1;
               dly = -1;
            end else begin
               dly--;
            end
         end else if ($urandom_range(15, 0) == 0) begin
            sdr_ack = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each new SDRAM request or BRAM strobe.
   initial begin
      logic prev_req;
      logic prev_ack;
      exp_t e;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         chk("wait_tracks_req", 64'(ioctl_wait), 64'(sdr_req));
         if (prev_req && !sdr_req)
            chk("req_drop_needs_ack", 64'(prev_ack), 64'(1));
         if ((sdr_req && !prev_req) || bram_wr) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 64'(sdr_req && !prev_req), 64'(0));
            end else begin
               e = exp_q.pop_front();
               if (sdr_req && !prev_req) begin
                  chk("write_is_sdram", 64'(1), 64'(e.is_sdr));
                  chk("sdr_addr", 64'(sdr_addr), 64'(e.addr));
                  chk("sdr_data", 64'(sdr_data), 64'(e.data));
                  chk("sdr_be", 64'(sdr_be), 64'(e.be));
               end
               if (bram_wr) begin
                  chk("write_is_bram", 64'(0), 64'(e.is_sdr));
                  chk("bram_addr", 64'(bram_addr), 64'(e.addr));
                  chk("bram_data", 64'(bram_data), 64'(e.data[7:0]));
                  chk("bram_cs", 64'(bram_cs), 64'(e.cs));
               end
            end
         end
         if (load_done) ld_count++;
         prev_req = sdr_req;
         prev_ack = sdr_ack;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      while (ioctl_wait === 1'b1) begin
         if (guard > 300) begin
            chk("wait_timeout", 64'(ioctl_wait), 64'(0));
            return;
         end
         // Strobes during back-pressure must be ignored by the loader.
         if ($urandom_range(3, 0) == 0) begin
            ioctl_wr   = 1'b1;
            ioctl_dout = 8'($urandom);
         end
         tick();
         ioctl_wr = 1'b0;
         guard++;
      end
      ioctl_wr   = 1'b1;
      ioctl_dout = b;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic run_download(input logic [7:0] s[$], input int cut, input bit drop_now);
      logic [7:0] sent[$];
      int exp_reg;
      int ld0;
      int guard;
      sent = {};
      for (int i = 0; i < cut; i++) sent.push_back(s[i]);
      model_stream(sent, exp_reg);
      ld0 = ld_count;
      ioctl_download = 1'b1;
      tick(); tick();
      chk("region_start", 64'(region), 64'(0));
      for (int i = 0; i < cut; i++) begin
         send_byte(sent[i]);
         if (i == 0) chk("busy_after_first", 64'(busy), 64'(1));
         if (!(drop_now && i == cut - 1))
            repeat ($urandom_range(2, 0)) tick();
      end
      ioctl_download = 1'b0;
      guard = 0;
      while (ld_count == ld0 && guard < 400) begin
         tick();
         guard++;
      end
      repeat (4) tick();
      chk("load_done_pulses", 64'(ld_count - ld0), 64'(1));
      chk("busy_end", 64'(busy), 64'(0));
      chk("region_end", 64'(region), 64'(exp_reg));
      chk("sdr_req_end", 64'(sdr_req), 64'(0));
      chk("writes_missing", 64'(exp_q.size()), 64'(0));
      $display("download %0d: %0d of %0d bytes sent, final region %0d, abort_now %0d",
               dl_num, cut, s.size(), exp_reg, drop_now);
      exp_q.delete();
      dl_num++;
      repeat (2) tick();
   endtask

   task automatic add_random_record(inout logic [7:0] s[$]);
      int sz;
      sz = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      s.push_back(8'h00); s.push_back(8'h00);
      s.push_back(8'h00); s.push_back(8'(sz));
      for (int k = 0; k < sz; k++) s.push_back(8'($urandom));
   endtask

   initial begin
      logic [7:0] s[$];
      int nrec;
      int cut;
      rst = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_dout = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          64'({ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req, bram_wr, busy, load_done}),
          64'(0));
      chk("reset_bram", 64'({bram_addr, bram_data, bram_cs}), 64'(0));
      chk("reset_region", 64'(region), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Four linear SDRAM bytes to region 0.
      s = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
      run_download(s, s.size(), 1'b0);

      // Zero-size region 0, reorder_64 region 1, three BRAM bytes to region 2.
      s = '{8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h08,
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h00, 8'h00, 8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
      run_download(s, s.size(), 1'b0);

      // Two zero-size records, then two bytes that must land in region 2.
      s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h02, 8'h5A, 8'hA5};
      run_download(s, s.size(), 1'b0);

      // Download drops while an SDRAM write is still waiting for its ack.
      ack_min = 4;
      s = '{8'h00, 8'h00, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03};
      run_download(s, s.size(), 1'b1);
      ack_min = 0;

      // One record per region plus an extra one that must produce no writes.
      s = {};
      for (int r = 0; r < NR; r++) begin
         s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h05);
         for (int k = 0; k < 5; k++) s.push_back(8'($urandom));
      end
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h03);
      s.push_back(8'h99); s.push_back(8'h98); s.push_back(8'h97);
      run_download(s, s.size(), 1'b0);

      // Randomised downloads, some truncated mid-record or mid-header.
      for (int d = 0; d < 30; d++) begin
         s = {};
         nrec = $urandom_range(7, 0);
         for (int r = 0; r < nrec; r++) add_random_record(s);
         if ($urandom_range(2, 0) == 0) cut = $urandom_range(s.size(), 0);
         else cut = s.size();
         run_download(s, cut, 1'($urandom_range(1, 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #800000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
